// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU-64 host sequencer:
//   - opcode constants ADD/SUB/MUL/DIV as seen on req_opcode / alu_opcode
//   - host FSM state encoding (ST_DRAIN exists only with ALU_HOST_TIMEOUT_EN)
//   - default operand/result word width
// Optional feature macro: ALU_HOST_TIMEOUT_EN
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_LOAD_Y = 3'd3,
    ST_WAIT   = 3'd4,
`ifdef ALU_HOST_TIMEOUT_EN
    ST_RESP   = 3'd5,
    ST_DRAIN  = 3'd6
`else
    ST_RESP   = 3'd5
`endif
  } host_state_t;

endpackage

// File: rtl/alu_host_timer.sv
// ---------------------------------------------------------------------------
// alu_host_timer
// WAIT-state cycle counter for the host sequencer's abort path. The module
// only exists in builds with ALU_HOST_TIMEOUT_EN defined, since nothing else
// instantiates it.
// Ports:
//   clk      in   system clock, rising edge
//   rst_b    in   asynchronous active-low reset
//   clr      in   zero the counter (asserted the cycle before WAIT is entered)
//   en       in   count this cycle (high while in WAIT)
//   expired  out  high during the TIMEOUT-th consecutive counted cycle
// ---------------------------------------------------------------------------
`ifdef ALU_HOST_TIMEOUT_EN
module alu_host_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count holds k-1 during the k-th WAIT cycle, so the flag fires on cycle TIMEOUT
  assign expired = en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_host_sequencer.sv
// ---------------------------------------------------------------------------
// alu_host_sequencer
// Initiator side of the ALU-64 bgn/stop interface. Takes one operation per
// req_valid/req_ready handshake, pulses alu_bgn, presents x then y on
// alu_inbus, collects result words on the c5 (alu_rd_hi) / c6 (alu_rd_lo)
// strobes until alu_stop, and returns them on a resp_valid/resp_ready channel.
// Words are passed through unmodified; this block does no arithmetic.
//
// Optional feature macro: ALU_HOST_TIMEOUT_EN
//   Aborts WAIT after TIMEOUT cycles without alu_stop (resp_err=1), then holds
//   req_ready low for two DRAIN cycles after the response handshake.
//
// Ports:
//   clk, rst_b                      clock, asynchronous active-low reset
//   req_valid/req_ready             host request handshake (ready only in IDLE)
//   req_opcode, req_x, req_y        operation (00 add,01 sub,10 mul,11 div)
//   alu_bgn, alu_opcode, alu_inbus  to the ALU control unit / datapath
//   alu_outbus, alu_rd_hi,
//   alu_rd_lo, alu_stop             from the ALU datapath / control unit
//   resp_valid/resp_ready           response handshake
//   resp_hi, resp_lo, resp_err      captured words and timeout flag
//   busy                            high in every state except IDLE
// ---------------------------------------------------------------------------
module alu_host_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             alu_bgn,
  output logic [1:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_inbus,
  input  logic [WIDTH-1:0] alu_outbus,
  input  logic             alu_rd_hi,
  input  logic             alu_rd_lo,
  input  logic             alu_stop,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             resp_err,
  output logic             busy
);

  host_state_t      state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] inbus_q;
  logic             bgn_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;

`ifdef ALU_HOST_TIMEOUT_EN
  logic err_q;
  logic drain_cnt;
  logic timeout_hit;

  alu_host_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (state == ST_LOAD_Y),
    .en      (state == ST_WAIT),
    .expired (timeout_hit)
  );

  assign resp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign resp_err = 1'b0;
`endif

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign alu_bgn    = bgn_q;
  assign alu_opcode = op_q;
  assign alu_inbus  = inbus_q;
  assign resp_valid = valid_q;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;

  // All outputs are registered; each is loaded one cycle ahead of the state
  // in which it must be visible (e.g. inbus_q <= x_q while leaving ISSUE).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      inbus_q <= '0;
      bgn_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
      err_q     <= 1'b0;
      drain_cnt <= 1'b0;
`endif
    end else begin
      bgn_q   <= 1'b0;
      inbus_q <= '0;
      case (state)
        ST_IDLE: begin
          // ready_q comes up the first cycle after reset release
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            op_q    <= req_opcode;
            x_q     <= req_x;
            y_q     <= req_y;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef ALU_HOST_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            bgn_q   <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          inbus_q <= x_q;
          state   <= ST_LOAD_X;
        end
        ST_LOAD_X: begin
          inbus_q <= y_q;
          state   <= ST_LOAD_Y;
        end
        ST_LOAD_Y: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_rd_hi) hi_q <= alu_outbus;
          if (alu_rd_lo) lo_q <= alu_outbus;
          if (alu_stop) begin
            valid_q <= 1'b1;
            state   <= ST_RESP;
          end
`ifdef ALU_HOST_TIMEOUT_EN
          else if (timeout_hit) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
            if (err_q) begin
              // aborted ALU may still be sequencing; keep the host out briefly
              drain_cnt <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= ST_IDLE;
            end
`else
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
`endif
          end
        end
`ifdef ALU_HOST_TIMEOUT_EN
        ST_DRAIN: begin
          if (drain_cnt) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_host_sequencer.md
Name: alu_host_sequencer

Overview:
- Initiator side of the ALU-64 bgn/stop interface.
- Accepts one operation per valid/ready request from a host: opcode plus two 64-bit operands.
- Drives the ALU control unit's bgn/opcode and the datapath inbus in the required cycle order, then collects result words from outbus on the c5/c6 strobes.
- Returns a single response over a valid/ready channel. Sits between the CPU/bus wrapper and the ALU-64 core.

Parameters:
- WIDTH, 64, operand/result word width.
- TIMEOUT, 1023, max WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_opcode  in  2  00 add, 01 sub, 10 mul, 11 div
- req_x  in  WIDTH  operand 1
- req_y  in  WIDTH  operand 2
- alu_bgn  out  1  start pulse to control unit
- alu_opcode  out  2  opcode to control unit
- alu_inbus  out  WIDTH  operand bus to datapath
- alu_outbus  in  WIDTH  result bus from datapath
- alu_rd_hi  in  1  c5 strobe: outbus carries A (sum/diff, product high, remainder)
- alu_rd_lo  in  1  c6 strobe: outbus carries Q (product low, quotient)
- alu_stop  in  1  control unit stop
- resp_valid  out  1  response valid
- resp_ready  in  1  host accepts response
- resp_hi  out  WIDTH  word captured on alu_rd_hi
- resp_lo  out  WIDTH  word captured on alu_rd_lo; 0 for add/sub
- resp_err  out  1  timeout abort (always 0 without the macro)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: async on rst_b low. State IDLE. All outputs and captured registers 0; req_ready=1 once out of reset.
- States: IDLE, ISSUE, LOAD_X, LOAD_Y, WAIT, RESP.
- IDLE: on req_valid&req_ready, register opcode/x/y; clear hi/lo. Next state ISSUE.
- ISSUE: alu_bgn=1 for exactly this one cycle. Next state LOAD_X.
- LOAD_X: alu_inbus=x (control unit is in S1, c0 loads). Next state LOAD_Y.
- LOAD_Y: alu_inbus=y (c1 loads). Next state WAIT.
- alu_inbus=0 in every other state.
- alu_opcode: driven from the registered opcode from ISSUE through WAIT. It holds its last value in IDLE/RESP and must never change while the ALU is running.
- WAIT:
  - alu_rd_hi: capture alu_outbus into hi.
  - alu_rd_lo: capture alu_outbus into lo.
  - alu_stop: capture any strobe asserted in the same cycle, then go to RESP. Stop coincides with c5 for add/sub and with c6 for mul/div.
- Strobes/stop outside WAIT are ignored.
- RESP: resp_valid=1, resp_hi/lo/err stable until resp_ready. On handshake go to IDLE; the next request can be accepted no earlier than the following cycle.
- Latency: request accept to resp_valid is 5 cycles for add/sub. For mul/div it is data-independent of the host; bounded by the ALU at about 3*64+8 cycles.
- Arithmetic: no computation in this block; words are passed through unmodified.
- Reset mid-operation: immediate return to IDLE and any pending response is lost. The ALU shares rst_b and also returns to S0.

Optional Feature:
- Macro: ALU_HOST_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without alu_stop, go to RESP with resp_err=1 and hi/lo as captured so far.
  - The block then holds req_ready=0 for 2 extra cycles (DRAIN state) after the response handshake, to let the ALU settle.
  - alu_stop on the TIMEOUT cycle takes priority and gives a normal response.
- Without the macro: no counter, no DRAIN state, resp_err tied 0, WAIT indefinitely.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ADD/SUB/MUL/DIV (2'b00..2'b11)
  - host FSM state encoding
  - default WIDTH
- One natural sub-module: alu_host_timer, the WAIT cycle counter with terminal flag. It is instantiated only under ALU_HOST_TIMEOUT_EN.

Test Plan:
All scenarios are paired with the team's ALU-64 core.
- Add x=5, y=7, resp_ready=1 → resp_valid 5 cycles after accept; resp_hi=12, resp_lo=0, err=0.
- Sub x=3, y=5 → resp_hi=64'hFFFF_FFFF_FFFF_FFFE, resp_lo=0.
- Mul x=64'h1_0000_0000, y=64'h1_0000_0000 → resp_hi=1, resp_lo=0. Check that alu_opcode stays 10 throughout WAIT.
- Div x=100, y=7 → resp_hi=2, resp_lo=14.
- Backpressure: hold resp_ready=0 for 10 cycles → outputs stable, req_ready=0. A second req_valid is not accepted until the cycle after the handshake.
- Reset/timeout:
  - Drop rst_b during a mul WAIT → all outputs 0 immediately and IDLE.
  - With ALU_HOST_TIMEOUT_EN, TIMEOUT=16 and alu_stop stubbed low → resp_err=1 after 16 WAIT cycles, then 2 DRAIN cycles with req_ready=0.
